vga_pixel_out: RTL and testbench

VGA_PIXEL_OUT -- requirements
Module: vga_pixel_out

---
 rtl/vga_pixel_out.sv | 192 +++++++++++++++++++
 tb/tb_vga_pixel_out.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_out.sv
// vga_pixel_out: buffers upstream pixels in a small synchronous FIFO and
// replays them to the VGA pins, one entry per pixel_tick (clk / PIXEL_DIV).
// FILL waits until START_LEVEL pixels are buffered; RUN pops one per tick
// and falls back to FILL on underflow.
// Optional: define VGA_PIXEL_OUT_STATS_EN to enable the saturating 16-bit
// underflow/overflow event counters (otherwise they read constant 0).
module vga_pixel_out #(
    parameter int   COLOR_BITS     = 4,
    parameter int   META_BITS      = 4,
    parameter int   FIFO_ADDR_SIZE = 4,
    parameter int   PIXEL_DIV      = 4,
    parameter int   HIGH_WATER     = 10,
    parameter int   START_LEVEL    = 8,
    parameter logic SYNC_IDLE      = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_valid,
    output logic                  s_enable,
    input  logic                  s_hsync,
    input  logic                  s_vsync,
    input  logic [COLOR_BITS-1:0] s_red,
    input  logic [COLOR_BITS-1:0] s_grn,
    input  logic [COLOR_BITS-1:0] s_blu,
    input  logic [META_BITS-1:0]  s_meta,
    output logic                  vga_hsync,
    output logic                  vga_vsync,
    output logic [COLOR_BITS-1:0] vga_red,
    output logic [COLOR_BITS-1:0] vga_grn,
    output logic [COLOR_BITS-1:0] vga_blu,
    output logic [META_BITS-1:0]  vga_meta,
    output logic                  pixel_tick,
    output logic                  underflow,
    output logic                  overflow,
    output logic [15:0]           underflow_count,
    output logic [15:0]           overflow_count
);

    localparam int AW    = FIFO_ADDR_SIZE;
    localparam int LW    = AW + 1;
    localparam int DEPTH = 1 << AW;
    localparam int PW    = 2 + 3 * COLOR_BITS + META_BITS;
    localparam int CW    = (PIXEL_DIV > 1) ? $clog2(PIXEL_DIV) : 1;

    localparam logic [CW-1:0] DIV_LAST  = CW'(PIXEL_DIV - 1);
    localparam logic [LW-1:0] HW_LVL    = LW'(HIGH_WATER);
    localparam logic [LW-1:0] START_LVL = LW'(START_LEVEL);
    localparam logic [LW-1:0] DEPTH_LVL = LW'(DEPTH);
    // Blank pixel: sync lines at their idle level, colour and meta zero.
    localparam logic [PW-1:0] IDLE_PIX  = {SYNC_IDLE, SYNC_IDLE, {(PW-2){1'b0}}};

    typedef enum logic {S_FILL, S_RUN} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   div_cnt;
    logic [LW-1:0]   wr_ptr, rd_ptr, level;
    logic [PW-1:0]   mem [DEPTH];
    logic [PW-1:0]   pix_in;
    logic [PW-1:0]   pix_p1;
    logic            full, empty;
    logic            pop, push, under_evt, over_evt;

    assign pix_in = {s_hsync, s_vsync, s_red, s_grn, s_blu, s_meta};
    assign level  = wr_ptr - rd_ptr;
    assign full   = (level == DEPTH_LVL);
    assign empty  = (wr_ptr == rd_ptr);

    // A pop in the same clk frees a slot, so a push at full is still accepted.
    assign push     = s_valid && (!full || pop);
    assign over_evt = s_valid && full && !pop;

    assign pixel_tick = (div_cnt == DIV_LAST);

    // Free-running pixel clock divider
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            div_cnt <= '0;
        else if (div_cnt == DIV_LAST)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 1'b1;
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_FILL;
        else
            state <= state_nxt;
    end

    // FSM next state, pop request and underflow detection
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        under_evt = 1'b0;
        case (state)
            S_FILL: begin
                if (pixel_tick && (level >= START_LVL)) begin
                    pop       = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (pixel_tick) begin
                    if (empty) begin
                        under_evt = 1'b1;
                        state_nxt = S_FILL;
                    end else begin
                        pop = 1'b1;
                    end
                end
            end
            default: state_nxt = S_FILL;
        endcase
    end

    // FIFO storage write (data only, never reset)
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= pix_in;
    end

    // FIFO pointers; the extra MSB distinguishes full from empty
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Output pixel register: loads on pop, blanks on underflow, else holds
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pix_p1 <= IDLE_PIX;
        else if (pop)
            pix_p1 <= mem[rd_ptr[AW-1:0]];
        else if (under_evt)
            pix_p1 <= IDLE_PIX;
    end

    assign {vga_hsync, vga_vsync, vga_red, vga_grn, vga_blu, vga_meta} = pix_p1;

    // Upstream flow control from the registered FIFO level
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            s_enable <= 1'b0;
        else
            s_enable <= (level < HW_LVL);
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underflow <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (under_evt)
                underflow <= 1'b1;
            if (over_evt)
                overflow <= 1'b1;
        end
    end

`ifdef VGA_PIXEL_OUT_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Saturating event counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underflow_count <= '0;
            overflow_count  <= '0;
        end else begin
            if (under_evt)
                underflow_count <= sat_inc(underflow_count);
            if (over_evt)
                overflow_count <= sat_inc(overflow_count);
        end
    end
`else
    assign underflow_count = '0;
    assign overflow_count  = '0;
`endif

endmodule

// File: tb/tb_vga_pixel_out.sv
// Self-checking bench for vga_pixel_out with default parameters.
// Inputs are driven and outputs sampled on the falling clk edge.
module tb_vga_pixel_out;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        logic [3:0] m;
    } pix_t;

    typedef struct {
        pix_t in;
        pix_t exp;
    } vec_t;

    localparam pix_t IDLE_PIX = {1'b1, 1'b1, 16'h0000};
`ifdef VGA_PIXEL_OUT_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_enable;
    logic        s_hsync = 1'b0, s_vsync = 1'b0;
    logic [3:0]  s_red = '0, s_grn = '0, s_blu = '0, s_meta = '0;
    logic        vga_hsync, vga_vsync;
    logic [3:0]  vga_red, vga_grn, vga_blu, vga_meta;
    logic        pixel_tick, underflow, overflow;
    logic [15:0] underflow_count, overflow_count;
    pix_t        vga_pix;

    int checks = 0;
    int errors = 0;
    int ncyc = 0;
    int last_tick = 0;
    vec_t tbl [8];

    vga_pixel_out dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_enable(s_enable),
        .s_hsync(s_hsync), .s_vsync(s_vsync),
        .s_red(s_red), .s_grn(s_grn), .s_blu(s_blu), .s_meta(s_meta),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
        .vga_red(vga_red), .vga_grn(vga_grn), .vga_blu(vga_blu), .vga_meta(vga_meta),
        .pixel_tick(pixel_tick), .underflow(underflow), .overflow(overflow),
        .underflow_count(underflow_count), .overflow_count(overflow_count)
    );

    assign vga_pix = {vga_hsync, vga_vsync, vga_red, vga_grn, vga_blu, vga_meta};

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic pix_t mkpix(input int k);
        pix_t p;
        logic [7:0] b8;
        b8  = k[7:0];
        p.hs = b8[0];
        p.vs = b8[1];
        p.r  = b8[3:0] ^ 4'hA;
        p.g  = b8[7:4];
        p.b  = b8[3:0];
        p.m  = ~b8[3:0];
        return p;
    endfunction

    task automatic drive(input pix_t p);
        s_hsync = p.hs;
        s_vsync = p.vs;
        s_red   = p.r;
        s_grn   = p.g;
        s_blu   = p.b;
        s_meta  = p.m;
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        ncyc++;
    endtask

    // Wait (bounded) for a tick, then step past the edge that acts on it.
    task automatic wait_tick(input string name);
        int n;
        n = 0;
        while (pixel_tick !== 1'b1 && n < 8) begin
            cyc();
            n++;
        end
        chk(name, {31'd0, pixel_tick}, 32'd1);
        last_tick = ncyc;
        cyc();
    endtask

    task automatic check_reset(input string name);
        chk({name, "_s_enable"}, {31'd0, s_enable}, 32'd0);
        chk({name, "_tick"}, {31'd0, pixel_tick}, 32'd0);
        chk({name, "_vga"}, {14'd0, vga_pix}, {14'd0, IDLE_PIX});
        chk({name, "_flags"}, {30'd0, underflow, overflow}, 32'd0);
        chk({name, "_counts"}, {underflow_count, overflow_count}, 32'd0);
    endtask

    // Leaves the bench on the falling edge just before the first active edge.
    task automatic do_reset(input string name);
        s_valid = 1'b0;
        reset   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_reset(name);
        reset = 1'b0;
        ncyc  = 0;
    endtask

    initial begin
        int prev;
        int exp_q [$];

        for (int i = 0; i < 8; i++) begin
            tbl[i].in  = mkpix(i * 37 + 5);
            tbl[i].exp = mkpix(i * 37 + 5);
        end

        // Fill to START_LEVEL, stream out, underflow, then resume
        do_reset("rst1");
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].in);
            s_valid = 1'b1;
            cyc();
            if (i == 0) chk("s_enable_after_reset", {31'd0, s_enable}, 32'd1);
        end
        s_valid = 1'b0;
        chk("fill_holds_idle", {14'd0, vga_pix}, {14'd0, IDLE_PIX});
        wait_tick("tick0");
        chk("first_pixel", {14'd0, vga_pix}, {14'd0, tbl[0].exp});
        for (int i = 1; i < 8; i++) begin
            prev = last_tick;
            wait_tick("tick_run");
            chk("tick_period", last_tick - prev, 32'd4);
            chk("run_pixel", {14'd0, vga_pix}, {14'd0, tbl[i].exp});
        end
        wait_tick("tick_underflow");
        chk("underflow_flag", {31'd0, underflow}, 32'd1);
        chk("underflow_blank", {14'd0, vga_pix}, {14'd0, IDLE_PIX});
        chk("underflow_count", {16'd0, underflow_count}, STATS);
        chk("no_overflow_1", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            drive(tbl[7 - i].in);
            s_valid = 1'b1;
            cyc();
        end
        s_valid = 1'b0;
        chk("fill_after_underflow_idle", {14'd0, vga_pix}, {14'd0, IDLE_PIX});
        wait_tick("tick_resume");
        chk("resume_pixel", {14'd0, vga_pix}, {14'd0, tbl[7].exp});
        chk("underflow_count_hold", {16'd0, underflow_count}, STATS);

        // Continuous push: s_enable drops one clk after level reaches 10
        do_reset("rst2");
        for (int k = 1; k <= 14; k++) begin
            drive(mkpix(k));
            s_valid = 1'b1;
            cyc();
            if (k == 10) chk("s_enable_level9", {31'd0, s_enable}, 32'd1);
            if (k == 11) chk("s_enable_level10", {31'd0, s_enable}, 32'd0);
            if (k == 12) chk("stream_first", {14'd0, vga_pix}, {14'd0, mkpix(1)});
            if (k == 14) chk("s_enable_inflight", {31'd0, s_enable}, 32'd0);
        end
        s_valid = 1'b0;
        chk("no_overflow_latency", {31'd0, overflow}, 32'd0);

        // Ignore s_enable: full FIFO, push+pop at full, then dropped pixels.
        // Ticks fall on clk 4,8,12,...; RUN starts at clk 12, level 16 after clk 18.
        do_reset("rst3");
        for (int k = 1; k <= 25; k++) begin
            drive(mkpix(k));
            s_valid = (k != 19);
            cyc();
            if (k == 19) chk("full_s_enable", {31'd0, s_enable}, 32'd0);
            if (k == 20) begin
                chk("push_pop_full_no_ovf", {31'd0, overflow}, 32'd0);
                chk("push_pop_full_pixel", {14'd0, vga_pix}, {14'd0, mkpix(3)});
            end
        end
        s_valid = 1'b0;
        chk("overflow_flag", {31'd0, overflow}, 32'd1);
        chk("overflow_count", {16'd0, overflow_count}, 4 * STATS);
        for (int k = 5; k <= 18; k++) exp_q.push_back(k);
        exp_q.push_back(20);
        exp_q.push_back(24);
        foreach (exp_q[j]) begin
            wait_tick("tick_drain");
            chk("drain_pixel", {14'd0, vga_pix}, {14'd0, mkpix(exp_q[j])});
        end
        wait_tick("tick_drain_end");
        chk("drain_underflow", {31'd0, underflow}, 32'd1);
        chk("overflow_sticky", {31'd0, overflow}, 32'd1);

        // Asynchronous reset between clk edges while streaming
        do_reset("rst4");
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].in);
            s_valid = 1'b1;
            cyc();
        end
        s_valid = 1'b0;
        wait_tick("tick_pre_async");
        chk("pre_async_pixel", {14'd0, vga_pix}, {14'd0, tbl[0].exp});
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_reset("async_rst");
        @(negedge clk);
        reset = 1'b0;
        ncyc  = 0;
        for (int i = 0; i < 8; i++) begin
            drive(tbl[7 - i].in);
            s_valid = 1'b1;
            cyc();
        end
        s_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wait_tick("tick_post_async");
            chk("post_async_pixel", {14'd0, vga_pix}, {14'd0, tbl[7 - i].exp});
        end
        wait_tick("tick_post_async_end");
        chk("post_async_empty", {31'd0, underflow}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
